seq_vector_detector: RTL and testbench

//  Parametrised sequence detector on a WIDTH-bit input vector (generalises the x1/x2/x3 -> g/f circuit).
//  A programmable pattern of DEPTH symbols is loaded at run time; qualified input symbols are tracked.

---
 rtl/seq_vector_detector.sv | 86 ++++++++
 tb/tb_seq_vector_detector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_vector_detector.sv
// Sequence detector for a run-time programmable pattern of DEPTH WIDTH-bit symbols.
// Emits a registered match pulse (g), a match-parity toggle (f) and a saturating match count.
module seq_vector_detector #(
    parameter int WIDTH   = 3,
    parameter int DEPTH   = 4,
    parameter int OVERLAP = 1,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [WIDTH-1:0]       x,
    input  logic                   load,
    input  logic [WIDTH*DEPTH-1:0] pat_in,
    output logic                   g,
    output logic                   f,
    output logic [CNT_W-1:0]       match_cnt
);
    localparam int PW = WIDTH * DEPTH;
    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    logic [PW-1:0]    pat_reg;
    logic [PW-1:0]    hist_reg;
    logic [PW-1:0]    hist_next;
    logic [FW-1:0]    fill_reg;
    logic [FW-1:0]    fill_next;
    logic             g_reg;
    logic             f_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [DEPTH-1:0] sym_eq;
    logic             match;

    // Newest symbol enters the LSB slice so the window lines up with the pattern's last slice.
    assign hist_next = {hist_reg[PW-WIDTH-1:0], x};
    assign fill_next = (fill_reg == FULL) ? FULL : fill_reg + 1'b1;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sym_cmp
            assign sym_eq[gi] = (hist_next[gi*WIDTH +: WIDTH] == pat_reg[gi*WIDTH +: WIDTH]);
        end
    endgenerate

    assign match = (fill_next == FULL) && (&sym_eq);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg  <= '0;
            hist_reg <= '0;
            fill_reg <= '0;
            g_reg    <= 1'b0;
            f_reg    <= 1'b0;
            cnt_reg  <= '0;
        end else if (load) begin
            pat_reg  <= pat_in;
            hist_reg <= '0;
            fill_reg <= '0;
            g_reg    <= 1'b0;
        end else if (en) begin
            g_reg <= match;
            if (match) begin
                f_reg <= ~f_reg;
                if (!(&cnt_reg)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                // Overlapping mode keeps the window so the next symbol can complete another match.
                if (OVERLAP != 0) begin
                    hist_reg <= hist_next;
                    fill_reg <= FULL;
                end else begin
                    hist_reg <= '0;
                    fill_reg <= '0;
                end
            end else begin
                hist_reg <= hist_next;
                fill_reg <= fill_next;
            end
        end else begin
            g_reg <= 1'b0;
        end
    end

    assign g         = g_reg;
    assign f         = f_reg;
    assign match_cnt = cnt_reg;
endmodule

// File: tb/tb_seq_vector_detector.sv
// Directed bench for seq_vector_detector: three instances (overlap, non-overlap, 2-bit counter)
// share stimulus; a queue-based model pushes expected outputs, popped after each edge.
module tb_seq_vector_detector;
    logic        clk = 1'b0;
    logic        rst, en, load;
    logic [2:0]  x;
    logic [11:0] pat_in;
    logic        g0, f0, g1, f1, g2, f2;
    logic [7:0]  cnt0, cnt1;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;
    int step_no = 0;
    int gp[3];

    typedef struct packed {
        logic [2:0] g;
        logic [2:0] f;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] c2;
    } exp_t;
    exp_t sb[$];

    // Model state: list of qualified symbols since the last clear, oldest first.
    int          msym[3][16];
    int          mlen[3];
    logic [11:0] mpat[3];
    logic        mf[3];
    logic        mg[3];
    int          mcnt[3];

    always #5 clk = ~clk;

    seq_vector_detector #(.WIDTH(3), .DEPTH(4), .OVERLAP(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .g(g0), .f(f0), .match_cnt(cnt0));
    seq_vector_detector #(.WIDTH(3), .DEPTH(4), .OVERLAP(0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .g(g1), .f(f1), .match_cnt(cnt1));
    seq_vector_detector #(.WIDTH(3), .DEPTH(4), .OVERLAP(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .pat_in(pat_in),
        .g(g2), .f(f2), .match_cnt(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic e,
                        input logic [2:0] xv, input logic [11:0] p);
        exp_t ex;
        bit   hit;
        int   maxc;
        rst = r; load = l; en = e; x = xv; pat_in = p;
        for (int i = 0; i < 3; i++) begin
            maxc = (i == 2) ? 3 : 255;
            if (r) begin
                mpat[i] = '0; mlen[i] = 0; mf[i] = 1'b0; mcnt[i] = 0; mg[i] = 1'b0;
            end else if (l) begin
                mpat[i] = p; mlen[i] = 0; mg[i] = 1'b0;
            end else if (e) begin
                if (mlen[i] == 16) begin
                    for (int k = 0; k < 15; k++) msym[i][k] = msym[i][k+1];
                    mlen[i] = 15;
                end
                msym[i][mlen[i]] = int'(xv);
                mlen[i]++;
                hit = (mlen[i] >= 4);
                if (hit) begin
                    for (int k = 0; k < 4; k++)
                        if (msym[i][mlen[i]-4+k] != int'((mpat[i] >> (3*(3-k))) & 12'h7)) hit = 0;
                end
                mg[i] = hit;
                if (hit) begin
                    mf[i] = ~mf[i];
                    if (mcnt[i] < maxc) mcnt[i]++;
                    if (i == 1) mlen[i] = 0;
                end
            end else begin
                mg[i] = 1'b0;
            end
        end
        ex.g  = {mg[2], mg[1], mg[0]};
        ex.f  = {mf[2], mf[1], mf[0]};
        ex.c0 = 8'(mcnt[0]);
        ex.c1 = 8'(mcnt[1]);
        ex.c2 = 2'(mcnt[2]);
        sb.push_back(ex);
        @(posedge clk);
        #1;
        step_no++;
        ex = sb.pop_front();
        chk("g0", 32'(g0), 32'(ex.g[0]));
        chk("g1", 32'(g1), 32'(ex.g[1]));
        chk("g2", 32'(g2), 32'(ex.g[2]));
        chk("f0", 32'(f0), 32'(ex.f[0]));
        chk("f1", 32'(f1), 32'(ex.f[1]));
        chk("f2", 32'(f2), 32'(ex.f[2]));
        chk("cnt0", 32'(cnt0), 32'(ex.c0));
        chk("cnt1", 32'(cnt1), 32'(ex.c1));
        chk("cnt2", 32'(cnt2), 32'(ex.c2));
        gp[0] += int'(g0); gp[1] += int'(g1); gp[2] += int'(g2);
        $display("step %0d rst=%b load=%b en=%b x=%0d g=%b%b%b f=%b%b%b cnt=%0d/%0d/%0d",
                 step_no, r, l, e, xv, g0, g1, g2, f0, f1, f2, cnt0, cnt1, cnt2);
    endtask

    task automatic sym(input logic [2:0] xv);
        step(1'b0, 1'b0, 1'b1, xv, 12'h000);
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < 3; i++) gp[i] = 0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; x = '0; pat_in = '0;
        // Reset asserted together with load and en: reset must win.
        step(1'b1, 1'b1, 1'b1, 3'd5, 12'hB9F);
        step(1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
        chk("rst_g0", 32'(g0), 32'd0);
        chk("rst_f0", 32'(f0), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);

        // Basic match 5,6,3,7
        step(1'b0, 1'b1, 1'b0, 3'd0, 12'hB9F);
        sym(3'd5); sym(3'd6); sym(3'd3);
        chk("t1_no_early_g", 32'(g0), 32'd0);
        sym(3'd7);
        chk("t1_g", 32'(g0), 32'd1);
        chk("t1_f", 32'(f0), 32'd1);
        chk("t1_cnt", 32'(cnt0), 32'd1);
        step(1'b0, 1'b0, 1'b0, 3'd7, 12'h000);
        chk("t1_g_pulse", 32'(g0), 32'd0);

        // All-ones pattern, overlap vs non-overlap
        step(1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
        step(1'b0, 1'b1, 1'b0, 3'd0, 12'h249);
        clear_pulses();
        repeat (7) sym(3'd1);
        chk("t2_ov_pulses", 32'(gp[0]), 32'd4);
        chk("t2_nov_pulses", 32'(gp[1]), 32'd1);
        chk("t2_ov_f", 32'(f0), 32'd0);
        chk("t2_ov_cnt", 32'(cnt0), 32'd4);
        chk("t2_nov_cnt", 32'(cnt1), 32'd1);

        // en gaps are transparent; a wrong symbol prevents a match
        step(1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
        step(1'b0, 1'b1, 1'b0, 3'd0, 12'hB9F);
        sym(3'd5); sym(3'd6);
        step(1'b0, 1'b0, 1'b0, 3'd0, 12'h000);
        sym(3'd3); sym(3'd7);
        chk("t3_gap_g", 32'(g0), 32'd1);
        chk("t3_gap_cnt", 32'(cnt0), 32'd1);
        clear_pulses();
        sym(3'd5); sym(3'd6); sym(3'd2); sym(3'd3); sym(3'd7);
        chk("t3_nomatch_pulses", 32'(gp[0]), 32'd0);

        // Reset mid-sequence clears the pattern to zero
        step(1'b0, 1'b1, 1'b0, 3'd0, 12'hB9F);
        sym(3'd5); sym(3'd6); sym(3'd3);
        step(1'b1, 1'b0, 1'b1, 3'd0, 12'h000);
        sym(3'd7);
        chk("t4_g", 32'(g0), 32'd0);
        chk("t4_cnt", 32'(cnt0), 32'd0);
        sym(3'd0); sym(3'd0); sym(3'd0);
        chk("t4_zero_early", 32'(g0), 32'd0);
        sym(3'd0);
        chk("t4_zero_match", 32'(g0), 32'd1);

        // load wins over en and restarts the history
        step(1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
        sym(3'd5); sym(3'd6);
        step(1'b0, 1'b1, 1'b1, 3'd3, 12'hB9F);
        clear_pulses();
        sym(3'd3); sym(3'd7);
        chk("t5_no_match", 32'(gp[0]), 32'd0);
        sym(3'd5); sym(3'd6); sym(3'd3); sym(3'd7);
        chk("t5_match", 32'(g0), 32'd1);

        // Counter saturation on the 2-bit instance
        step(1'b1, 1'b0, 1'b0, 3'd0, 12'h000);
        step(1'b0, 1'b1, 1'b0, 3'd0, 12'h249);
        clear_pulses();
        repeat (8) sym(3'd1);
        chk("t6_pulses", 32'(gp[2]), 32'd5);
        chk("t6_cnt_sat", 32'(cnt2), 32'd3);
        chk("t6_f", 32'(f2), 32'd1);
        chk("t6_nov_cnt", 32'(cnt1), 32'd2);

        // Random qualified/unqualified 0/1 symbols against the all-ones pattern
        for (int n = 0; n < 60; n++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 1)),
                 12'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
